// File: rtl/act_unit_pipe.sv
// Multi-lane activation stage: ReLU / leaky ReLU / clamp / truncate with saturation,
// two-stage valid/ready pipeline. Optional saturation counter enabled by `define SAT_CNT_EN.
module act_unit_pipe #(
    parameter int DATA_WIDTH       = 16,
    parameter int WEIGHT_INT_WIDTH = 4,
    parameter int NUM_LANES        = 4,
    parameter int LEAK_SHIFT       = 3,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [1:0]                          in_mode,
    input  logic [NUM_LANES*2*DATA_WIDTH-1:0]   in_x,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [NUM_LANES*DATA_WIDTH-1:0]     out_y,
    output logic [NUM_LANES-1:0]                out_sat,
    input  logic                                sat_clr,
    output logic [CNT_WIDTH-1:0]                sat_count
);

    localparam int XW      = 2 * DATA_WIDTH;
    localparam int TW      = WEIGHT_INT_WIDTH + 1;
    localparam int SLC_LSB = XW - WEIGHT_INT_WIDTH - DATA_WIDTH;

    localparam logic [DATA_WIDTH-1:0] MAXP = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MAXN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        MODE_RELU  = 2'd0,
        MODE_LEAKY = 2'd1,
        MODE_CLAMP = 2'd2,
        MODE_TRUNC = 2'd3
    } mode_e;

    logic                            adv;
    logic                            s1_valid_reg;
    mode_e                           s1_mode_reg;
    logic [NUM_LANES*DATA_WIDTH-1:0] s1_slice_reg;
    logic [NUM_LANES-1:0]            s1_sign_reg;
    logic [NUM_LANES-1:0]            s1_pos_ovf_reg;
    logic [NUM_LANES-1:0]            s1_neg_ovf_reg;

    logic [NUM_LANES*DATA_WIDTH-1:0] slice_next;
    logic [NUM_LANES-1:0]            sign_next;
    logic [NUM_LANES-1:0]            pos_ovf_next;
    logic [NUM_LANES-1:0]            neg_ovf_next;
    logic [NUM_LANES-1:0]            unused_lsbs;

    logic                            out_valid_reg;
    logic [NUM_LANES*DATA_WIDTH-1:0] out_y_reg;
    logic [NUM_LANES-1:0]            out_sat_reg;
    logic [NUM_LANES*DATA_WIDTH-1:0] y_next;
    logic [NUM_LANES-1:0]            sat_next;

    // Both stages advance together; a stalled output freezes the whole pipe.
    assign adv      = !out_valid_reg || out_ready;
    assign in_ready = adv;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_s1_lane
            logic [XW-1:0] x;
            logic [TW-1:0] top;

            assign x   = in_x[gi*XW +: XW];
            assign top = x[XW-1 -: TW];

            assign sign_next[gi]                          = x[XW-1];
            assign pos_ovf_next[gi]                       = !x[XW-1] && (top != '0);
            assign neg_ovf_next[gi]                       = x[XW-1] && (top != '1);
            assign slice_next[gi*DATA_WIDTH +: DATA_WIDTH] = x[XW-1-WEIGHT_INT_WIDTH -: DATA_WIDTH];

            // Fractional bits below the output slice are dropped by design.
            if (SLC_LSB > 0) begin : g_lsb
                assign unused_lsbs[gi] = ^x[SLC_LSB-1:0];
            end else begin : g_no_lsb
                assign unused_lsbs[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_reg   <= 1'b0;
            s1_mode_reg    <= MODE_RELU;
            s1_slice_reg   <= '0;
            s1_sign_reg    <= '0;
            s1_pos_ovf_reg <= '0;
            s1_neg_ovf_reg <= '0;
        end else if (adv) begin
            s1_valid_reg   <= in_valid;
            s1_mode_reg    <= mode_e'(in_mode);
            s1_slice_reg   <= slice_next;
            s1_sign_reg    <= sign_next;
            s1_pos_ovf_reg <= pos_ovf_next;
            s1_neg_ovf_reg <= neg_ovf_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_s2_lane
            logic [DATA_WIDTH-1:0]        slice;
            logic                         neg;
            logic                         povf;
            logic                         novf;
            logic signed [DATA_WIDTH-1:0] leak_v;
            logic [DATA_WIDTH-1:0]        y_lane;
            logic                         sat_lane;

            assign slice = s1_slice_reg[gi*DATA_WIDTH +: DATA_WIDTH];
            assign neg   = s1_sign_reg[gi];
            assign povf  = s1_pos_ovf_reg[gi];
            assign novf  = s1_neg_ovf_reg[gi];

            always_comb begin
                y_lane   = slice;
                sat_lane = 1'b0;
                leak_v   = novf ? MAXN : slice;
                unique case (s1_mode_reg)
                    MODE_RELU, MODE_LEAKY: begin
                        if (!neg) begin
                            if (povf) begin
                                y_lane   = MAXP;
                                sat_lane = 1'b1;
                            end
                        end else if (s1_mode_reg == MODE_RELU) begin
                            y_lane = '0;
                        end else begin
                            y_lane   = leak_v >>> LEAK_SHIFT;
                            sat_lane = novf;
                        end
                    end
                    MODE_CLAMP: begin
                        if (povf) begin
                            y_lane   = MAXP;
                            sat_lane = 1'b1;
                        end else if (novf) begin
                            y_lane   = MAXN;
                            sat_lane = 1'b1;
                        end
                    end
                    MODE_TRUNC: begin
                        y_lane = slice;
                    end
                    default: begin
                        y_lane = slice;
                    end
                endcase
            end

            assign y_next[gi*DATA_WIDTH +: DATA_WIDTH] = y_lane;
            assign sat_next[gi]                        = sat_lane;
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_reg <= 1'b0;
            out_y_reg     <= '0;
            out_sat_reg   <= '0;
        end else if (adv) begin
            out_valid_reg <= s1_valid_reg;
            out_y_reg     <= y_next;
            out_sat_reg   <= sat_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_y     = out_y_reg;
    assign out_sat   = out_sat_reg;

`ifdef SAT_CNT_EN
    localparam int POP_W = $clog2(NUM_LANES + 1);
    localparam int SUM_W = ((CNT_WIDTH > POP_W) ? CNT_WIDTH : POP_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_WIDTH){1'b0}}, {CNT_WIDTH{1'b1}}};

    logic [CNT_WIDTH-1:0] sat_count_reg;
    logic [POP_W-1:0]     pop;
    logic [SUM_W-1:0]     sum;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            pop = pop + POP_W'(out_sat_reg[i]);
        end
    end

    assign sum = SUM_W'(sat_count_reg) + SUM_W'(pop);

    // Clear has priority over a coincident handshake; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sat_count_reg <= '0;
        end else if (sat_clr) begin
            sat_count_reg <= '0;
        end else if (out_valid_reg && out_ready) begin
            sat_count_reg <= (sum > CNT_MAX) ? '1 : sum[CNT_WIDTH-1:0];
        end
    end

    assign sat_count = sat_count_reg;
`else
    logic unused_sat_clr;
    assign unused_sat_clr = sat_clr;
    assign sat_count      = '0;
`endif

endmodule
